// File: rtl/alu_opcodes.sv
// Shared opcode constants and result bundle for the registered 16-bit ALU.
// Imported by both the datapath and the testbench.
package alu_opcodes;

    localparam logic [4:0] OP_ADD       = 5'd0;
    localparam logic [4:0] OP_SUB       = 5'd1;
    localparam logic [4:0] OP_MUL       = 5'd2;
    localparam logic [4:0] OP_DIV       = 5'd3;
    localparam logic [4:0] OP_AND       = 5'd4;
    localparam logic [4:0] OP_OR        = 5'd5;
    localparam logic [4:0] OP_XOR       = 5'd6;
    localparam logic [4:0] OP_NOT       = 5'd7;
    localparam logic [4:0] OP_NAND      = 5'd8;
    localparam logic [4:0] OP_NOR       = 5'd9;
    localparam logic [4:0] OP_XNOR      = 5'd10;
    localparam logic [4:0] OP_UGT       = 5'd11;
    localparam logic [4:0] OP_ULT       = 5'd12;
    localparam logic [4:0] OP_UET       = 5'd13;
    localparam logic [4:0] OP_SGT       = 5'd14;
    localparam logic [4:0] OP_SLT       = 5'd15;
    localparam logic [4:0] OP_SET       = 5'd16;
    localparam logic [4:0] OP_LSL       = 5'd17;
    localparam logic [4:0] OP_LSR       = 5'd18;
    localparam logic [4:0] OP_ASL       = 5'd19;
    localparam logic [4:0] OP_ASR       = 5'd20;
    localparam logic [4:0] OP_RL        = 5'd21;
    localparam logic [4:0] OP_RR        = 5'd22;

    typedef struct packed {
        logic [15:0] alu_out;
        logic [15:0] upper;
        logic [15:0] rem;
        logic        zero;
        logic        negative;
        logic        carryout;
        logic        borrowout;
        logic        overflow;
        logic        divbyzero;
        logic        gt;
        logic        lt;
        logic        et;
    } alu_res_t;

    function automatic logic is_valid_op(input logic [4:0] op);
        return op <= OP_RR;
    endfunction

endpackage

// File: rtl/alu_comb.sv
// Combinational ALU datapath: computes the result word, product/remainder halves
// and all flags for one opcode. Unused flags stay 0.
module alu_comb
    import alu_opcodes::*;
(
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic        carryin,
    input  logic        borrowin,
    input  logic [4:0]  sel_alu,
    output alu_res_t    res
);

    logic [3:0]  amt;
    logic [16:0] sum;
    logic [16:0] diff;
    logic [31:0] prod;
    logic [15:0] quot;
    logic [15:0] rmd;
    logic [15:0] shl;
    logic [15:0] shr;
    logic [15:0] asr;
    logic [15:0] rotl;
    logic [15:0] rotr;
    logic        div0;

    assign amt  = in1[3:0];
    assign sum  = {1'b0, in0} + {1'b0, in1} + {16'b0, carryin};
    // Bit 16 of the 17-bit difference is exactly the unsigned borrow.
    assign diff = {1'b0, in0} - {1'b0, in1} - {16'b0, borrowin};
    assign prod = 32'(in0) * 32'(in1);
    assign div0 = (in1 == 16'd0);
    assign quot = div0 ? 16'd0 : in0 / in1;
    assign rmd  = div0 ? 16'd0 : in0 % in1;
    assign shl  = in0 << amt;
    assign shr  = in0 >> amt;
    assign asr  = 16'($signed(in0) >>> amt);
    assign rotl = (in0 << amt) | (in0 >> (5'd16 - {1'b0, amt}));
    assign rotr = (in0 >> amt) | (in0 << (5'd16 - {1'b0, amt}));

    always_comb begin
        res = '0;
        case (sel_alu)
            OP_ADD: begin
                res.alu_out  = sum[15:0];
                res.carryout = sum[16];
                res.overflow = (in0[15] == in1[15]) && (sum[15] != in0[15]);
            end
            OP_SUB: begin
                res.alu_out   = diff[15:0];
                res.borrowout = diff[16];
                res.overflow  = (in0[15] != in1[15]) && (diff[15] != in0[15]);
            end
            OP_MUL: begin
                res.alu_out  = prod[15:0];
                res.upper    = prod[31:16];
                res.overflow = (prod[31:16] != 16'd0);
            end
            OP_DIV: begin
                res.alu_out   = quot;
                res.rem       = rmd;
                res.divbyzero = div0;
            end
            OP_AND:  res.alu_out = in0 & in1;
            OP_OR:   res.alu_out = in0 | in1;
            OP_XOR:  res.alu_out = in0 ^ in1;
            OP_NOT:  res.alu_out = ~in0;
            OP_NAND: res.alu_out = ~(in0 & in1);
            OP_NOR:  res.alu_out = ~(in0 | in1);
            OP_XNOR: res.alu_out = ~(in0 ^ in1);
            OP_UGT: begin
                res.gt      = (in0 > in1);
                res.alu_out = {15'd0, res.gt};
            end
            OP_ULT: begin
                res.lt      = (in0 < in1);
                res.alu_out = {15'd0, res.lt};
            end
            OP_UET: begin
                res.et      = (in0 == in1);
                res.alu_out = {15'd0, res.et};
            end
            OP_SGT: begin
                res.gt      = ($signed(in0) > $signed(in1));
                res.alu_out = {15'd0, res.gt};
            end
            OP_SLT: begin
                res.lt      = ($signed(in0) < $signed(in1));
                res.alu_out = {15'd0, res.lt};
            end
            OP_SET: begin
                res.et      = (in0 == in1);
                res.alu_out = {15'd0, res.et};
            end
            OP_LSL:  res.alu_out = shl;
            OP_LSR:  res.alu_out = shr;
            OP_ASL: begin
                res.alu_out  = shl;
                res.overflow = (shl[15] != in0[15]);
            end
            OP_ASR:  res.alu_out = asr;
            OP_RL:   res.alu_out = rotl;
            OP_RR:   res.alu_out = rotr;
            default: res = '0;
        endcase

        if (is_valid_op(sel_alu)) begin
            res.zero     = (res.alu_out == 16'd0);
            res.negative = res.alu_out[15];
        end
    end

endmodule

// File: rtl/alu_top.sv
// Registered 16-bit ALU: one-cycle latency from operands to every output,
// with synchronous active-low clear.
module alu_top
    import alu_opcodes::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in0,
    input  logic [15:0] in1,
    input  logic        carryin,
    input  logic        borrowin,
    input  logic [4:0]  sel_alu,
    output logic [15:0] alu_out,
    output logic [15:0] upper_alubits,
    output logic [15:0] remainder_alubits,
    output logic        zero_flag,
    output logic        negative_flag,
    output logic        carryout_flag,
    output logic        borrowout_flag,
    output logic        alu_overflow,
    output logic        divbyzero_flag,
    output logic        GT_flag,
    output logic        LT_flag,
    output logic        ET_flag
);

    alu_res_t res_d;
    alu_res_t res_q;

    alu_comb u_alu_comb (
        .in0      (in0),
        .in1      (in1),
        .carryin  (carryin),
        .borrowin (borrowin),
        .sel_alu  (sel_alu),
        .res      (res_d)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_q <= '0;
        end else begin
            res_q <= res_d;
        end
    end

    assign alu_out           = res_q.alu_out;
    assign upper_alubits     = res_q.upper;
    assign remainder_alubits = res_q.rem;
    assign zero_flag         = res_q.zero;
    assign negative_flag     = res_q.negative;
    assign carryout_flag     = res_q.carryout;
    assign borrowout_flag    = res_q.borrowout;
    assign alu_overflow      = res_q.overflow;
    assign divbyzero_flag    = res_q.divbyzero;
    assign GT_flag           = res_q.gt;
    assign LT_flag           = res_q.lt;
    assign ET_flag           = res_q.et;

endmodule

// File: tb/tb_alu_top.sv
// Directed testbench for alu_top with hand-computed expected values.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
module tb_alu_top;
    import alu_opcodes::*;

    logic        clk;
    logic        rst_n;
    logic [15:0] in0;
    logic [15:0] in1;
    logic        carryin;
    logic        borrowin;
    logic [4:0]  sel_alu;
    logic [15:0] alu_out;
    logic [15:0] upper_alubits;
    logic [15:0] remainder_alubits;
    logic        zero_flag;
    logic        negative_flag;
    logic        carryout_flag;
    logic        borrowout_flag;
    logic        alu_overflow;
    logic        divbyzero_flag;
    logic        GT_flag;
    logic        LT_flag;
    logic        ET_flag;

    int tests;
    int fails;

    // Flags packed as {Z,N,C,B,V,D,GT,LT,ET}
    logic [8:0]  flags;
    logic [56:0] all_out;
    assign flags = {zero_flag, negative_flag, carryout_flag, borrowout_flag, alu_overflow,
                    divbyzero_flag, GT_flag, LT_flag, ET_flag};
    assign all_out = {alu_out, upper_alubits, remainder_alubits, flags};

    alu_top dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in0               (in0),
        .in1               (in1),
        .carryin           (carryin),
        .borrowin          (borrowin),
        .sel_alu           (sel_alu),
        .alu_out           (alu_out),
        .upper_alubits     (upper_alubits),
        .remainder_alubits (remainder_alubits),
        .zero_flag         (zero_flag),
        .negative_flag     (negative_flag),
        .carryout_flag     (carryout_flag),
        .borrowout_flag    (borrowout_flag),
        .alu_overflow      (alu_overflow),
        .divbyzero_flag    (divbyzero_flag),
        .GT_flag           (GT_flag),
        .LT_flag           (LT_flag),
        .ET_flag           (ET_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apply(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input logic bi);
        @(negedge clk);
        sel_alu  = op;
        in0      = a;
        in1      = b;
        carryin  = ci;
        borrowin = bi;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sel_alu = OP_ADD; in0 = 16'hFFFF; in1 = 16'h0001; carryin = 1'b1; borrowin = 1'b0;
        @(posedge clk);
        #1;
        tests++;
        if (all_out !== 57'd0) begin
            fails++;
            $display("FAIL reset_state got=%h exp=0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_add();
        apply(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        tests++;
        if ({alu_out, flags} !== {16'h0000, 9'b1_0_1_0_0_0_0_0_0}) begin
            fails++;
            $display("FAIL add_wrap got=%h/%b exp=0000/101000000", alu_out, flags);
        end
        apply(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
        tests++;
        if ({alu_out, flags} !== {16'h8000, 9'b0_1_0_0_1_0_0_0_0}) begin
            fails++;
            $display("FAIL add_ovf got=%h/%b exp=8000/010010000", alu_out, flags);
        end
        apply(OP_ADD, 16'h0010, 16'h0020, 1'b1, 1'b1);
        tests++;
        if ({alu_out, flags} !== {16'h0031, 9'b0}) begin
            fails++;
            $display("FAIL add_carryin got=%h/%b exp=0031/000000000", alu_out, flags);
        end
    endtask

    task automatic test_sub();
        apply(OP_SUB, 16'd5, 16'd10, 1'b0, 1'b0);
        tests++;
        if ({alu_out, flags} !== {16'd65531, 9'b0_1_0_1_0_0_0_0_0}) begin
            fails++;
            $display("FAIL sub_borrow got=%h/%b exp=fffb/010100000", alu_out, flags);
        end
        apply(OP_SUB, 16'd10, 16'd5, 1'b1, 1'b1);
        tests++;
        if ({alu_out, flags} !== {16'd4, 9'b0}) begin
            fails++;
            $display("FAIL sub_borrowin got=%h/%b exp=0004/000000000", alu_out, flags);
        end
        apply(OP_SUB, 16'h8000, 16'h0001, 1'b0, 1'b0);
        tests++;
        if ({alu_out, flags} !== {16'h7FFF, 9'b0_0_0_0_1_0_0_0_0}) begin
            fails++;
            $display("FAIL sub_ovf got=%h/%b exp=7fff/000010000", alu_out, flags);
        end
    endtask

    task automatic test_mul_div();
        apply(OP_MUL, 16'd200, 16'd200, 1'b0, 1'b0);
        tests++;
        if ({alu_out, upper_alubits, flags} !== {16'd40000, 16'd0, 9'b0_1_0_0_0_0_0_0_0}) begin
            fails++;
            $display("FAIL mul_small got=%h/%h/%b exp=9c40/0000/010000000",
                     alu_out, upper_alubits, flags);
        end
        apply(OP_MUL, 16'h1234, 16'h0100, 1'b0, 1'b0);
        tests++;
        if ({alu_out, upper_alubits, alu_overflow} !== {16'h3400, 16'h0012, 1'b1}) begin
            fails++;
            $display("FAIL mul_big got=%h/%h/%b exp=3400/0012/1",
                     alu_out, upper_alubits, alu_overflow);
        end
        apply(OP_DIV, 16'd103, 16'd10, 1'b0, 1'b0);
        tests++;
        if ({alu_out, remainder_alubits, upper_alubits, flags} !==
            {16'd10, 16'd3, 16'd0, 9'b0}) begin
            fails++;
            $display("FAIL div got=%h/%h/%b exp=000a/0003/000000000",
                     alu_out, remainder_alubits, flags);
        end
        apply(OP_DIV, 16'd100, 16'd0, 1'b0, 1'b0);
        tests++;
        if ({alu_out, remainder_alubits, flags} !== {16'd0, 16'd0, 9'b1_0_0_0_0_1_0_0_0}) begin
            fails++;
            $display("FAIL div_zero got=%h/%h/%b exp=0000/0000/100001000",
                     alu_out, remainder_alubits, flags);
        end
    endtask

    task automatic test_logic();
        logic [4:0]  ops [7] = '{OP_AND, OP_OR, OP_XOR, OP_NOT, OP_NAND, OP_NOR, OP_XNOR};
        logic [15:0] exp [7] = '{16'h3030, 16'hFCFC, 16'hCCCC, 16'h0F0F,
                                 16'hCFCF, 16'h0303, 16'h3333};
        for (int i = 0; i < 7; i++) begin
            apply(ops[i], 16'hF0F0, 16'h3C3C, 1'b1, 1'b1);
            tests++;
            if ({alu_out, flags} !== {exp[i], 1'b0, exp[i][15], 7'b0}) begin
                fails++;
                $display("FAIL logic_op%0d got=%h/%b exp=%h", ops[i], alu_out, flags, exp[i]);
            end
        end
    endtask

    task automatic test_compare();
        apply(OP_SGT, 16'hFFFE, 16'hFFFB, 1'b0, 1'b0);
        tests++;
        if ({alu_out, flags} !== {16'd1, 9'b0_0_0_0_0_0_1_0_0}) begin
            fails++;
            $display("FAIL sgt got=%h/%b exp=0001/000000100", alu_out, flags);
        end
        apply(OP_UET, 16'd7, 16'd7, 1'b0, 1'b0);
        tests++;
        if ({alu_out, flags} !== {16'd1, 9'b0_0_0_0_0_0_0_0_1}) begin
            fails++;
            $display("FAIL uet got=%h/%b exp=0001/000000001", alu_out, flags);
        end
        apply(OP_SLT, 16'hFFFB, 16'd2, 1'b0, 1'b0);
        tests++;
        if ({alu_out, flags} !== {16'd1, 9'b0_0_0_0_0_0_0_1_0}) begin
            fails++;
            $display("FAIL slt got=%h/%b exp=0001/000000010", alu_out, flags);
        end
        apply(OP_UGT, 16'hFFFE, 16'd2, 1'b0, 1'b0);
        tests++;
        if ({alu_out, GT_flag} !== {16'd1, 1'b1}) begin
            fails++;
            $display("FAIL ugt got=%h/%b exp=0001/1", alu_out, GT_flag);
        end
        apply(OP_SGT, 16'hFFFE, 16'd2, 1'b0, 1'b0);
        tests++;
        if ({alu_out, flags} !== {16'd0, 9'b1_0_0_0_0_0_0_0_0}) begin
            fails++;
            $display("FAIL sgt_false got=%h/%b exp=0000/100000000", alu_out, flags);
        end
        apply(OP_ULT, 16'hFFFB, 16'd2, 1'b0, 1'b0);
        tests++;
        if ({alu_out, LT_flag} !== {16'd0, 1'b0}) begin
            fails++;
            $display("FAIL ult_false got=%h/%b exp=0000/0", alu_out, LT_flag);
        end
    endtask

    task automatic test_shift();
        apply(OP_ASR, 16'hFFF0, 16'd2, 1'b0, 1'b0);
        tests++;
        if (alu_out !== 16'hFFFC || negative_flag !== 1'b1) begin
            fails++;
            $display("FAIL asr got=%h/%b exp=fffc/1", alu_out, negative_flag);
        end
        apply(OP_RL, 16'hC001, 16'd2, 1'b0, 1'b0);
        tests++;
        if (alu_out !== 16'h0007) begin
            fails++;
            $display("FAIL rl got=%h exp=0007", alu_out);
        end
        apply(OP_RR, 16'hC001, 16'd2, 1'b0, 1'b0);
        tests++;
        if (alu_out !== 16'h7000) begin
            fails++;
            $display("FAIL rr got=%h exp=7000", alu_out);
        end
        apply(OP_ASL, 16'hA000, 16'd1, 1'b0, 1'b0);
        tests++;
        if ({alu_out, alu_overflow} !== {16'h4000, 1'b1}) begin
            fails++;
            $display("FAIL asl got=%h/%b exp=4000/1", alu_out, alu_overflow);
        end
        apply(OP_LSR, 16'h8000, 16'h00FF, 1'b0, 1'b0);
        tests++;
        if (alu_out !== 16'h0001) begin
            fails++;
            $display("FAIL lsr got=%h exp=0001", alu_out);
        end
        apply(OP_LSL, 16'h0001, 16'd15, 1'b0, 1'b0);
        tests++;
        if ({alu_out, negative_flag, alu_overflow} !== {16'h8000, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL lsl got=%h/%b/%b exp=8000/1/0", alu_out, negative_flag, alu_overflow);
        end
        apply(OP_RL, 16'h1234, 16'd0, 1'b0, 1'b0);
        tests++;
        if (alu_out !== 16'h1234) begin
            fails++;
            $display("FAIL rl_zero got=%h exp=1234", alu_out);
        end
    endtask

    task automatic test_invalid();
        for (int op = 23; op < 32; op += 4) begin
            apply(5'(op), 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
            tests++;
            if (all_out !== 57'd0) begin
                fails++;
                $display("FAIL invalid_op%0d got=%h exp=0", op, all_out);
            end
        end
    endtask

    task automatic test_reset_mid_op();
        apply(OP_ADD, 16'd1, 16'd1, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        sel_alu = OP_MUL; in0 = 16'd200; in1 = 16'd200;
        @(posedge clk);
        #1;
        tests++;
        if (all_out !== 57'd0) begin
            fails++;
            $display("FAIL reset_mul got=%h exp=0", all_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({alu_out, upper_alubits} !== {16'd40000, 16'd0}) begin
            fails++;
            $display("FAIL reset_release got=%h/%h exp=9c40/0000", alu_out, upper_alubits);
        end
    endtask

    task automatic test_back_to_back();
        apply(OP_ADD, 16'd100, 16'd23, 1'b0, 1'b0);
        tests++;
        if (alu_out !== 16'd123) begin
            fails++;
            $display("FAIL b2b_add got=%h exp=007b", alu_out);
        end
        apply(OP_XOR, 16'hAAAA, 16'h5555, 1'b0, 1'b0);
        tests++;
        if (alu_out !== 16'hFFFF || carryout_flag !== 1'b0) begin
            fails++;
            $display("FAIL b2b_xor got=%h/%b exp=ffff/0", alu_out, carryout_flag);
        end
        apply(OP_DIV, 16'd7, 16'd2, 1'b0, 1'b0);
        tests++;
        if ({alu_out, remainder_alubits} !== {16'd3, 16'd1}) begin
            fails++;
            $display("FAIL b2b_div got=%h/%h exp=0003/0001", alu_out, remainder_alubits);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        in0      = '0;
        in1      = '0;
        carryin  = 1'b0;
        borrowin = 1'b0;
        sel_alu  = '0;
        test_reset();
        test_add();
        test_sub();
        test_mul_div();
        test_logic();
        test_compare();
        test_shift();
        test_invalid();
        test_reset_mid_op();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
